// File: rtl/rename_dispatch_pkg.sv
// Shared types and constants for the rename/dispatch slice.
// Provides: register-file sizing, RV32 opcode constants, preg/areg types,
// the renamed-instruction payload struct and the immediate decoder.
package rename_dispatch_pkg;

  localparam int unsigned NUM_AREG = 32;
  localparam int unsigned NUM_PREG = 64;
  localparam int unsigned PREG_W   = 6;
  localparam int unsigned AREG_W   = 5;
  localparam int unsigned FL_DEPTH = NUM_PREG - NUM_AREG;
  localparam int unsigned FL_PTR_W = 5;
  localparam int unsigned FL_CNT_W = 6;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_U     = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;

  // Renamed instruction presented to the issue queue
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    preg_t       src1_p;
    preg_t       src2_p;
    preg_t       dest_p;
    preg_t       old_dest_p;
    logic [31:0] imm;
    logic        src1_ready;
    logic        src2_ready;
  } uiq_entry_t;

  // Sign/shift-extended immediate for the supported formats; R and others give 0
  function automatic logic [31:0] decode_imm(input logic [31:0] instr);
    case (instr[6:0])
      OP_I, OP_LOAD: return {{20{instr[31]}}, instr[31:20]};
      OP_STORE:      return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_U:          return {instr[31:12], 12'b0};
      default:       return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/rename_dispatch_if.sv
// Handshake/bus bundle between fetch/ROB/FUs and the rename stage.
// master: environment side (drives in_*, stall_in, retire_*, wb_*).
// slave:  rename stage side (drives stall_out and out_*).
interface rename_dispatch_if;
  import rename_dispatch_pkg::*;

  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        stall_in;
  logic        retire_valid;
  preg_t       retire_old_preg;
  logic        wb_valid;
  preg_t       wb_preg;

  logic        stall_out;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  preg_t       out_src1_p;
  preg_t       out_src2_p;
  preg_t       out_dest_p;
  preg_t       out_old_dest_p;
  logic [31:0] out_imm;
  logic        out_src1_ready;
  logic        out_src2_ready;

  modport master (
    output in_valid, in_pc, in_instr, stall_in, retire_valid, retire_old_preg, wb_valid, wb_preg,
    input  stall_out, out_valid, out_pc, out_opcode, out_funct3, out_funct7, out_src1_p,
           out_src2_p, out_dest_p, out_old_dest_p, out_imm, out_src1_ready, out_src2_ready
  );

  modport slave (
    input  in_valid, in_pc, in_instr, stall_in, retire_valid, retire_old_preg, wb_valid, wb_preg,
    output stall_out, out_valid, out_pc, out_opcode, out_funct3, out_funct7, out_src1_p,
           out_src2_p, out_dest_p, out_old_dest_p, out_imm, out_src1_ready, out_src2_ready
  );

endinterface

// File: rtl/rename_dispatch_free_list_fifo.sv
// Circular free list of physical registers; resets full with p32..p63 in order.
// Ports: clk, rstn (async active-low), pop_i (take head), push_i/push_preg_i
// (return a preg at tail), head_preg_o (preg popped this cycle), count_o (occupancy).
module rename_dispatch_free_list_fifo
  import rename_dispatch_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                pop_i,
  input  logic                push_i,
  input  preg_t               push_preg_i,
  output preg_t               head_preg_o,
  output logic [FL_CNT_W-1:0] count_o
);

  preg_t               mem_q [FL_DEPTH];
  logic [FL_PTR_W-1:0] head_q, head_d;
  logic [FL_PTR_W-1:0] tail_q, tail_d;
  logic [FL_CNT_W-1:0] count_q, count_d;
  logic                do_pop;
  logic                do_push;

  // Pointer/occupancy update; a push into a full list is only legal alongside a pop
  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != FL_CNT_W'(FL_DEPTH)) || do_pop);
    head_d  = do_pop  ? head_q + FL_PTR_W'(1) : head_q;
    tail_d  = do_push ? tail_q + FL_PTR_W'(1) : tail_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + FL_CNT_W'(1);
      2'b01:   count_d = count_q - FL_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Full at reset, so tail coincides with head
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) mem_q[i] <= PREG_W'(FL_DEPTH + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= FL_CNT_W'(FL_DEPTH);
    end else begin
      if (do_push) mem_q[tail_q] <= push_preg_i;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_preg_o = mem_q[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/rename_dispatch.sv
// Decode/rename stage feeding the unified issue queue.
// Ports: clk, rstn (async active-low), bus (rename_dispatch_if.slave): fetched
// instruction in, UIQ stall, ROB retire, FU writeback; renamed instruction out
// (registered) plus combinational stall_out back to fetch.
// Build option WAKEUP_BYPASS_EN: a writeback hitting a source in the accept cycle
// marks it ready directly; without it the instruction is held one cycle instead.
module rename_dispatch
  import rename_dispatch_pkg::*;
(
  input logic             clk,
  input logic             rstn,
  rename_dispatch_if.slave bus
);

  preg_t               rat_q [NUM_AREG];
  preg_t               rat_d [NUM_AREG];
  logic [NUM_PREG-1:0] busy_q, busy_d;
  uiq_entry_t          out_q, out_d;

  logic [6:0]          opcode;
  areg_t               rd, rs1, rs2;
  logic                is_r, is_i, is_u, is_load, is_store;
  logic                supported, needs_dest, use_src1, use_src2;
  preg_t               src1_p, src2_p;
  logic                wb_hit1, wb_hit2;
  logic                src1_ready, src2_ready;
  logic                bypass_stall, stall_c;
  logic                accept, alloc, push;
  preg_t               fl_head;
  logic [FL_CNT_W-1:0] fl_count;

  assign opcode = bus.in_instr[6:0];
  assign rd     = bus.in_instr[11:7];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];

  // Decode, source lookup (pre-update RAT) and stall generation
  always_comb begin
    is_r       = (opcode == OP_R);
    is_i       = (opcode == OP_I);
    is_u       = (opcode == OP_U);
    is_load    = (opcode == OP_LOAD);
    is_store   = (opcode == OP_STORE);
    supported  = is_r || is_i || is_u || is_load || is_store;
    needs_dest = (is_r || is_i || is_u || is_load) && (rd != '0);
    use_src1   = is_r || is_i || is_load || is_store;
    use_src2   = is_r || is_store;
    src1_p     = use_src1 ? rat_q[rs1] : '0;
    src2_p     = use_src2 ? rat_q[rs2] : '0;
    wb_hit1    = bus.wb_valid && use_src1 && (bus.wb_preg == src1_p);
    wb_hit2    = bus.wb_valid && use_src2 && (bus.wb_preg == src2_p);
`ifdef WAKEUP_BYPASS_EN
    bypass_stall = 1'b0;
    src1_ready   = !busy_q[src1_p] || wb_hit1;
    src2_ready   = !busy_q[src2_p] || wb_hit2;
`else
    bypass_stall = bus.in_valid && (wb_hit1 || wb_hit2);
    src1_ready   = !busy_q[src1_p];
    src2_ready   = !busy_q[src2_p];
`endif
    // No push->pop bypass: an empty list stalls even with a same-cycle retire
    stall_c = bus.stall_in || (bus.in_valid && needs_dest && (fl_count == '0)) || bypass_stall;
    accept  = bus.in_valid && !stall_c && supported;
    alloc   = accept && needs_dest;
    push    = bus.retire_valid && (bus.retire_old_preg != '0);
  end

  // Next output register, RAT and busy table
  always_comb begin
    out_d = out_q;
    if (!bus.stall_in) begin
      out_d = '0;
      if (accept) begin
        out_d.valid      = 1'b1;
        out_d.pc         = bus.in_pc;
        out_d.opcode     = opcode;
        out_d.funct3     = bus.in_instr[14:12];
        out_d.funct7     = bus.in_instr[31:25];
        out_d.src1_p     = src1_p;
        out_d.src2_p     = src2_p;
        out_d.dest_p     = alloc ? fl_head : '0;
        out_d.old_dest_p = alloc ? rat_q[rd] : '0;
        out_d.imm        = decode_imm(bus.in_instr);
        out_d.src1_ready = src1_ready;
        out_d.src2_ready = src2_ready;
      end
    end

    rat_d = rat_q;
    if (alloc) rat_d[rd] = fl_head;

    // Allocation overrides a same-cycle wakeup of the same preg
    busy_d = busy_q;
    if (bus.wb_valid) busy_d[bus.wb_preg] = 1'b0;
    if (alloc)        busy_d[fl_head]     = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned a = 0; a < NUM_AREG; a++) rat_q[a] <= PREG_W'(a);
      busy_q <= '0;
      out_q  <= '0;
    end else begin
      rat_q  <= rat_d;
      busy_q <= busy_d;
      out_q  <= out_d;
    end
  end

  rename_dispatch_free_list_fifo u_free_list (
    .clk        (clk),
    .rstn       (rstn),
    .pop_i      (alloc),
    .push_i     (push),
    .push_preg_i(bus.retire_old_preg),
    .head_preg_o(fl_head),
    .count_o    (fl_count)
  );

  assign bus.stall_out      = stall_c;
  assign bus.out_valid      = out_q.valid;
  assign bus.out_pc         = out_q.pc;
  assign bus.out_opcode     = out_q.opcode;
  assign bus.out_funct3     = out_q.funct3;
  assign bus.out_funct7     = out_q.funct7;
  assign bus.out_src1_p     = out_q.src1_p;
  assign bus.out_src2_p     = out_q.src2_p;
  assign bus.out_dest_p     = out_q.dest_p;
  assign bus.out_old_dest_p = out_q.old_dest_p;
  assign bus.out_imm        = out_q.imm;
  assign bus.out_src1_ready = out_q.src1_ready;
  assign bus.out_src2_ready = out_q.src2_ready;

endmodule

// File: tb/tb_rename_dispatch.sv
// Self-checking bench for rename_dispatch: directed scenarios followed by random
// traffic, all compared against a queue/array model of rename behaviour.
module tb_rename_dispatch;
  import rename_dispatch_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rename_dispatch_if bus ();

  rename_dispatch dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Reference model: RAT, busy set, free list, ROB-order list of old mappings
  int          rat [32];
  bit          busy [64];
  int          fl [$];
  int          rob [$];
  bit          e_valid, e_r1, e_r2, last_acc;
  logic [31:0] e_pc, e_imm;
  int          e_op, e_f3, e_f7, e_s1, e_s2, e_dest, e_old;
  logic [31:0] pc_ctr;
  int          vectors, miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 32; a++) rat[a] = a;
    for (int p = 0; p < 64; p++) busy[p] = 1'b0;
    fl.delete();
    for (int p = 32; p < 64; p++) fl.push_back(p);
    rob.delete();
    e_valid = 0; e_pc = '0; e_op = 0; e_f3 = 0; e_f7 = 0; e_s1 = 0; e_s2 = 0;
    e_dest = 0; e_old = 0; e_imm = '0; e_r1 = 0; e_r2 = 0;
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == OP_I || op == OP_LOAD) return 32'($signed(ins[31:20]));
    if (op == OP_STORE)              return 32'($signed({ins[31:25], ins[11:7]}));
    if (op == OP_U)                  return {ins[31:12], 12'h000};
    return 32'h0;
  endfunction

  function automatic logic [31:0] enc_i(input int rd, input int rs1, input int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), 3'b000, 5'(rd), OP_I};
  endfunction

  function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), OP_R};
  endfunction

  function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], OP_STORE};
  endfunction

  task automatic set_in(input logic v, input logic [31:0] ins);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc    = pc_ctr;
    pc_ctr       = pc_ctr + 32'd4;
  endtask

  task automatic quiet_side();
    bus.stall_in = 0; bus.retire_valid = 0; bus.retire_old_preg = '0;
    bus.wb_valid = 0; bus.wb_preg = '0;
  endtask

  task automatic compare_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
    chk("fl_count", 32'(dut.u_free_list.count_o), 32'(fl.size()));
    if (e_valid) begin
      chk("out_pc", bus.out_pc, e_pc);
      chk("out_opcode", 32'(bus.out_opcode), 32'(e_op));
      chk("out_funct3", 32'(bus.out_funct3), 32'(e_f3));
      chk("out_funct7", 32'(bus.out_funct7), 32'(e_f7));
      chk("out_src1_p", 32'(bus.out_src1_p), 32'(e_s1));
      chk("out_src2_p", 32'(bus.out_src2_p), 32'(e_s2));
      chk("out_dest_p", 32'(bus.out_dest_p), 32'(e_dest));
      chk("out_old_dest_p", 32'(bus.out_old_dest_p), 32'(e_old));
      chk("out_imm", bus.out_imm, e_imm);
      chk("out_src1_ready", 32'(bus.out_src1_ready), 32'(e_r1));
      chk("out_src2_ready", 32'(bus.out_src2_ready), 32'(e_r2));
    end
  endtask

  // One clock: check stall_out, advance the model at the edge, check registered outputs
  task automatic cycle();
    logic [31:0] ins;
    logic [6:0]  op;
    int          rd, rs1, rs2, s1, s2, wbp, newp;
    bit          sup, nd, u1, u2, hit1, hit2, stall, acc;
    ins  = bus.in_instr;
    op   = ins[6:0];
    rd   = int'(ins[11:7]);
    rs1  = int'(ins[19:15]);
    rs2  = int'(ins[24:20]);
    sup  = op inside {OP_R, OP_I, OP_U, OP_LOAD, OP_STORE};
    nd   = (op inside {OP_R, OP_I, OP_U, OP_LOAD}) && rd != 0;
    u1   = op inside {OP_R, OP_I, OP_LOAD, OP_STORE};
    u2   = op inside {OP_R, OP_STORE};
    s1   = u1 ? rat[rs1] : 0;
    s2   = u2 ? rat[rs2] : 0;
    wbp  = int'(bus.wb_preg);
    hit1 = bus.wb_valid && u1 && wbp == s1;
    hit2 = bus.wb_valid && u2 && wbp == s2;
    stall = bus.stall_in || (bus.in_valid && nd && fl.size() == 0);
`ifndef WAKEUP_BYPASS_EN
    stall = stall || (bus.in_valid && (hit1 || hit2));
`endif
    acc = bus.in_valid && !stall && sup;
    last_acc = acc;
    #1;
    chk("stall_out", 32'(bus.stall_out), 32'(stall));
    @(posedge clk);
    if (!bus.stall_in) begin
      e_valid = acc;
      e_pc = acc ? bus.in_pc : '0;
      e_op = acc ? int'(op) : 0;
      e_f3 = acc ? int'(ins[14:12]) : 0;
      e_f7 = acc ? int'(ins[31:25]) : 0;
      e_s1 = acc ? s1 : 0;
      e_s2 = acc ? s2 : 0;
      e_imm = acc ? ref_imm(ins) : '0;
`ifdef WAKEUP_BYPASS_EN
      e_r1 = acc && (!busy[s1] || hit1);
      e_r2 = acc && (!busy[s2] || hit2);
`else
      e_r1 = acc && !busy[s1];
      e_r2 = acc && !busy[s2];
`endif
      e_dest = (acc && nd) ? fl[0] : 0;
      e_old  = (acc && nd) ? rat[rd] : 0;
    end
    if (bus.wb_valid) busy[wbp] = 1'b0;
    if (acc && nd) begin
      newp = fl.pop_front();
      busy[newp] = 1'b1;
      rob.push_back(rat[rd]);
      rat[rd] = newp;
    end
    if (bus.retire_valid && bus.retire_old_preg != '0) fl.push_back(int'(bus.retire_old_preg));
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_dest"}, 32'(bus.out_dest_p), 32'd0);
    chk({tag, "_pc"}, bus.out_pc, 32'd0);
    chk({tag, "_imm"}, bus.out_imm, 32'd0);
    chk({tag, "_count"}, 32'(dut.u_free_list.count_o), 32'd32);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    quiet_side();
    set_in(1'b0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rstn = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; pc_ctr = 32'h1000;
    apply_reset();

    // 1: addi x1,x0,5 then add x2,x1,x1 sources the fresh p32, not yet ready
    set_in(1'b1, enc_i(1, 0, 5)); cycle();
    chk("t1_dest_p32", 32'(bus.out_dest_p), 32'd32);
    set_in(1'b1, enc_r(2, 1, 1)); cycle();
    chk("t1_dest_p33", 32'(bus.out_dest_p), 32'd33);
    chk("t1_src1_p", 32'(bus.out_src1_p), 32'd32);
    chk("t1_src2_p", 32'(bus.out_src2_p), 32'd32);
    chk("t1_src1_rdy", 32'(bus.out_src1_ready), 32'd0);

    // 2: exhaust the free list, then a retire of p5 unblocks allocation one cycle later
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      set_in(1'b1, enc_i((i % 31) + 1, 0, i)); cycle();
    end
    set_in(1'b1, enc_i(2, 0, 77)); cycle();
    chk("t2_full_stall", 32'(bus.stall_out), 32'd1);
    bus.retire_valid = 1; bus.retire_old_preg = PREG_W'(5); cycle();
    bus.retire_valid = 0; bus.retire_old_preg = '0; cycle();
    chk("t2_dest_p5", 32'(bus.out_dest_p), 32'd5);

    // 3: UIQ stall holds output and rename state
    bus.stall_in = 1;
    set_in(1'b1, enc_r(7, 1, 2));
    repeat (3) cycle();
    chk("t3_hold_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_hold_dest", 32'(bus.out_dest_p), 32'd5);
    bus.stall_in = 0;

    // 4: store and rd==x0 allocate nothing, even with an empty free list
    set_in(1'b1, enc_s(3, 4, -4)); cycle();
    chk("t4_sw_imm", bus.out_imm, 32'hFFFF_FFFC);
    chk("t4_sw_dest", 32'(bus.out_dest_p), 32'd0);
    set_in(1'b1, enc_i(0, 0, 1)); cycle();
    chk("t4_x0_dest", 32'(bus.out_dest_p), 32'd0);
    chk("t4_x0_valid", 32'(bus.out_valid), 32'd1);

    // 5: wakeup of a source in the accept cycle
    apply_reset();
    set_in(1'b1, enc_i(1, 0, 5)); cycle();
    set_in(1'b1, enc_r(5, 1, 2));
    bus.wb_valid = 1; bus.wb_preg = PREG_W'(32);
    cycle();
    bus.wb_valid = 0;
    if (!last_acc) cycle();
    chk("t5_src1_rdy", 32'(bus.out_src1_ready), 32'd1);
    chk("t5_src1_p", 32'(bus.out_src1_p), 32'd32);

    // 6: asynchronous reset in mid-stream
    set_in(1'b1, enc_i(3, 0, 9)); cycle();
    set_in(1'b1, enc_i(4, 3, 1)); cycle();
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_reset_state("midrst");
    set_in(1'b0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    set_in(1'b1, enc_r(3, 1, 2)); cycle();
    chk("t6_rat_src1", 32'(bus.out_src1_p), 32'd1);
    chk("t6_rat_src2", 32'(bus.out_src2_p), 32'd2);
    chk("t6_dest", 32'(bus.out_dest_p), 32'd32);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      int          kind;
      ins  = $urandom;
      kind = int'($urandom_range(0, 5));
      case (kind)
        0:       ins[6:0] = OP_R;
        1:       ins[6:0] = OP_I;
        2:       ins[6:0] = OP_U;
        3:       ins[6:0] = OP_LOAD;
        4:       ins[6:0] = OP_STORE;
        default: ins[6:0] = 7'b1100011;
      endcase
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_instr = ins;
      bus.in_pc    = $urandom;
      bus.stall_in = ($urandom_range(0, 7) == 0);
      bus.retire_valid = 0; bus.retire_old_preg = '0;
      if (rob.size() > 0 && $urandom_range(0, 2) == 0) begin
        bus.retire_valid = 1;
        bus.retire_old_preg = PREG_W'(rob.pop_front());
      end else if ($urandom_range(0, 19) == 0) begin
        bus.retire_valid = 1;
      end
      bus.wb_valid = ($urandom_range(0, 1) == 1);
      bus.wb_preg  = PREG_W'($urandom_range(1, 63));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
